train_state_seq: RTL
====================

Name: train_state_seq

Overview:
Parametrised state-register/sequencer for the train controller FSMs. It holds the present state and loads an arbitrary next state on demand. Otherwise it steps up or down through states 0..LAST_STATE after a programmable dwell of enabled cycles, with wrap or saturate at the ends. It replaces fixed 4-bit loadable counters used as FSM state registers and adds direction, dwell timing, end flags and load range checking.

Parameters:
WIDTH, 4, state register width in bits (>=1)
LAST_STATE, 9, highest legal state; must be <= 2**WIDTH-1
RESET_STATE, 0, state after rst; must be <= LAST_STATE
DWELL, 1, enabled cycles spent in a state before stepping (>=1); DWELL=1 steps on every enabled cycle
MODE, 0, end behaviour: 0 = wrap, 1 = saturate

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
ld  input  1  load next_state this cycle
en  input  1  count enable
dir  input  1  step direction: 0 = up, 1 = down
next_state  input  WIDTH  value to load when ld=1
present_state  output  WIDTH  registered current state
at_first  output  1  combinational, present_state == 0
at_last  output  1  combinational, present_state == LAST_STATE
wrap  output  1  registered one-cycle pulse; a wrap occurred on the previous edge
load_err  output  1  registered one-cycle pulse; the previous load was out of range and was clamped

Behaviour:
- All registers update on posedge clk only. Priority per edge: rst > ld > en. No action when ld=0 and en=0.
- rst=1: present_state=RESET_STATE, dwell count=0, wrap=0, load_err=0. This applies mid-dwell and mid-load; there is no residue.
- ld=1:
  - present_state = next_state when next_state <= LAST_STATE, with load_err=0.
  - Otherwise present_state = LAST_STATE and load_err=1 for one cycle.
  - Dwell count is cleared to 0 and wrap=0.
  - en is ignored that cycle.
- ld=0, en=1 with dwell count < DWELL-1: dwell count increments and the state holds.
- ld=0, en=1 with dwell count == DWELL-1 is a step. Dwell count goes to 0 and:
  - up, state < LAST_STATE: state+1.
  - up, state == LAST_STATE: MODE 0 -> state 0 and wrap=1; MODE 1 -> state holds, wrap=0.
  - down, state > 0: state-1.
  - down, state == 0: MODE 0 -> LAST_STATE and wrap=1; MODE 1 -> state holds, wrap=0.
- en=0: dwell count and state hold.
- Changing dir mid-dwell does not clear the dwell count. The step uses dir as sampled on the step edge.
- wrap and load_err are 0 on every edge that does not set them. They never stay high for two cycles unless the event repeats.
- Arithmetic is done in WIDTH bits. The state never exceeds LAST_STATE, so no natural binary overflow is used.
- Dwell counter width is max(1, $clog2(DWELL)). Latency from the step edge to the new present_state is 0 cycles: the value is registered at that edge.

Decomposition:
- Package train_seq_pkg holds MODE_WRAP=0, MODE_SAT=1, DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module train_dwell_timer (params DWELL; ports clk, rst, clr, en, tick) produces the step tick.
  - tick is combinational: en && count==DWELL-1.
  - clr is driven by ld.
- The top level holds the state register, the end logic and the pulses.

Test Plan:
1. Default params (WIDTH=4, LAST=9, DWELL=1, MODE=0), rst then en=1 dir=0 for 12 cycles -> state 0,1,..,9,0,1. wrap=1 exactly in the cycle after the 9->0 step. at_last=1 while state=9.
2. DWELL=3, en=1 dir=0 from 0 -> state changes every 3rd edge (0,0,0,1,1,1,2). Drop en for 2 cycles mid-dwell -> the step is delayed by exactly 2 cycles.
3. ld=1 next_state=4'd5 with en=1 -> state=5 next cycle, dwell count cleared, load_err=0. ld=1 next_state=4'd13 -> state=9 and load_err=1 for one cycle.
4. MODE=1, dir=1 from state 2, en=1 for 4 cycles -> 1,0,0,0, wrap stays 0, at_first=1. Then dir=0 -> steps to 1.
5. MODE=0, dir=1 at state 0 -> state 9, wrap pulse. rst asserted with ld=1 in the same cycle -> state=RESET_STATE and load_err=0.
6. DWELL=3: two enabled cycles into a dwell, assert rst -> state=RESET_STATE. The next step then takes a full 3 enabled cycles.

Source files
------------

// File: rtl/train_seq_pkg.sv
// ----------------------------------------------------------------------------
// train_seq_pkg
// Shared constants for the train controller state sequencer.
//   MODE_WRAP / MODE_SAT : end-of-range behaviour selector values
//   DIR_UP / DIR_DOWN    : encoding of the step-direction input
// ----------------------------------------------------------------------------
package train_seq_pkg;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/train_dwell_timer.sv
// ----------------------------------------------------------------------------
// train_dwell_timer
// Counts enabled cycles spent in the present state and flags the cycle on
// which the sequencer is allowed to step.
//   i_clk  : rising-edge clock
//   i_rst  : synchronous reset, active-high
//   i_clr  : synchronous clear (driven by a state load)
//   i_en   : count enable
//   o_tick : combinational, i_en && count == DWELL-1
// ----------------------------------------------------------------------------
module train_dwell_timer #(
    parameter int DWELL = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int              CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   LP_TC = CW'(DWELL - 1);

    logic [CW-1:0] r_count;
    logic          w_at_tc;

    assign w_at_tc = (r_count == LP_TC);

    // With DWELL=1 the terminal count is 0, so the counter never leaves 0
    // and every enabled cycle ticks.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_at_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_tick = i_en && w_at_tc;

endmodule

// File: rtl/train_state_seq.sv
// ----------------------------------------------------------------------------
// train_state_seq
// Loadable state register / sequencer for the train controller FSMs. Steps
// up or down through 0..LAST_STATE after DWELL enabled cycles, wrapping or
// saturating at the ends; out-of-range loads are clamped to LAST_STATE.
//   i_clk           : rising-edge clock
//   i_rst           : synchronous reset, active-high
//   i_ld            : load i_next_state this cycle (beats i_en)
//   i_en            : count enable
//   i_dir           : step direction, 0 = up, 1 = down
//   i_next_state    : value to load
//   o_present_state : registered current state
//   o_at_first      : combinational, state == 0
//   o_at_last       : combinational, state == LAST_STATE
//   o_wrap          : one-cycle pulse, a wrap happened on the previous edge
//   o_load_err      : one-cycle pulse, the previous load was clamped
//
// action    | meaning
// ----------+-------------------------------------------------------------
// reset     | state = RESET_STATE, dwell cleared, pulses low
// load      | state = next_state (or LAST_STATE + load_err), dwell cleared
// dwell     | enabled, dwell not complete: count advances, state holds
// step      | enabled, dwell complete: move one state in i_dir
// hold      | no load, no enable: nothing changes
// ----------------------------------------------------------------------------
module train_state_seq
    import train_seq_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int LAST_STATE  = 9,
    parameter int RESET_STATE = 0,
    parameter int DWELL       = 1,
    parameter int MODE        = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_next_state,
    output logic [WIDTH-1:0] o_present_state,
    output logic             o_at_first,
    output logic             o_at_last,
    output logic             o_wrap,
    output logic             o_load_err
);

    localparam logic [WIDTH-1:0] LP_LAST  = WIDTH'(LAST_STATE);
    localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_STATE);
    localparam logic             LP_WRAPS = (MODE == MODE_WRAP);
    localparam logic             LP_SATS  = (MODE == MODE_SAT);

    logic [WIDTH-1:0] r_state;
    logic             r_wrap;
    logic             r_load_err;

    logic             w_tick;
    logic             w_load_oor;
    logic [WIDTH-1:0] w_step_state;
    logic             w_step_wrap;

    train_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_ld),
        .i_en   (i_en),
        .o_tick (w_tick)
    );

    // Compare in 32 bits so the range check stays meaningful (and quiet)
    // when LAST_STATE is the all-ones value of WIDTH.
    assign w_load_oor = (32'(i_next_state) > 32'(LAST_STATE));

    // Next state on a step. At an end, wrap mode jumps to the opposite end;
    // saturate mode leaves the default (hold) in place.
    always_comb begin
        w_step_state = r_state;
        w_step_wrap  = 1'b0;
        unique case (i_dir)
            DIR_UP: begin
                if (r_state != LP_LAST) begin
                    w_step_state = r_state + WIDTH'(1);
                end else if (LP_WRAPS && !LP_SATS) begin
                    w_step_state = '0;
                    w_step_wrap  = 1'b1;
                end
            end
            DIR_DOWN: begin
                if (r_state != '0) begin
                    w_step_state = r_state - WIDTH'(1);
                end else if (LP_WRAPS && !LP_SATS) begin
                    w_step_state = LP_LAST;
                    w_step_wrap  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= LP_RESET;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            // Pulses are low unless this edge sets them.
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (i_ld) begin
                if (w_load_oor) begin
                    r_state    <= LP_LAST;
                    r_load_err <= 1'b1;
                end else begin
                    r_state    <= i_next_state;
                end
            end else if (w_tick) begin
                r_state <= w_step_state;
                r_wrap  <= w_step_wrap;
            end
        end
    end

    assign o_present_state = r_state;
    assign o_at_first      = (r_state == '0);
    assign o_at_last       = (r_state == LP_LAST);
    assign o_wrap          = r_wrap;
    assign o_load_err      = r_load_err;

endmodule
